// File: rtl/uart_rx_framed.sv
// +----------------------------------------------------------------------------+
// | uart_rx_framed: oversampled UART receiver with parity, framing and break    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_rx_framed #(
  parameter int I_CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic                 o_rdy,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_busy
);

  localparam int CLKS_PER_BIT = I_CLOCK_FREQ / BAUD_RATE;
  localparam int H            = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_SAMP0    = CW'(H - 1);
  localparam logic [CW-1:0] C_SAMP1    = CW'(H);
  localparam logic [CW-1:0] C_SAMP2    = CW'(H + 1);
  localparam logic [3:0]    C_BIT_LAST = 4'(DATA_BITS - 1);
  localparam logic          C_STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          C_ODD      = (PARITY == 1);

  if (CLKS_PER_BIT < 8 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
    $error("uart_rx_framed: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q, hist_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 samp0_q, samp0_d, samp1_q, samp1_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_acc_q, perr_acc_d, ferr_acc_q, ferr_acc_d, brk_acc_q, brk_acc_d;
  logic                 rdy_q, rdy_d, perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 w_maj, w_mid, w_bit_end, w_ferr, w_brk;

  assign w_maj     = (samp0_q & samp1_q) | (samp0_q & sync2_q) | (samp1_q & sync2_q);
  assign w_mid     = (cnt_q == C_SAMP2);
  assign w_bit_end = (cnt_q == C_CNT_LAST);
  assign w_ferr    = ferr_acc_q | ~w_maj;
  // Only the first stop bit participates in break detection.
  assign w_brk     = (stop_idx_q == 1'b0) ? (brk_acc_q & ~w_maj) : brk_acc_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = w_bit_end ? '0 : cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    samp0_d    = (cnt_q == C_SAMP0) ? sync2_q : samp0_q;
    samp1_d    = (cnt_q == C_SAMP1) ? sync2_q : samp1_q;
    shreg_d    = shreg_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    brk_acc_d  = brk_acc_q;
    rdy_d      = 1'b0;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (hist_q && !sync2_q) begin
          state_d    = S_START;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          perr_acc_d = 1'b0;
          ferr_acc_d = 1'b0;
          brk_acc_d  = 1'b1;
        end
      end
      S_START: begin
        if (w_mid && w_maj) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (w_bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_mid) begin
          shreg_d   = {w_maj, shreg_q[DATA_BITS-1:1]};
          brk_acc_d = brk_acc_q & ~w_maj;
        end
        if (w_bit_end) begin
          if (bit_idx_q == C_BIT_LAST) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          else bit_idx_d = bit_idx_q + 4'd1;
        end
      end
      S_PARITY: begin
        if (w_mid) begin
          perr_acc_d = (^shreg_q) ^ w_maj ^ C_ODD;
          brk_acc_d  = brk_acc_q & ~w_maj;
        end
        if (w_bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (w_mid) begin
          ferr_acc_d = w_ferr;
          brk_acc_d  = w_brk;
          // Finish right after the last sample so a new start edge can land mid-stop-bit.
          if (stop_idx_q == C_STOP_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            rdy_d   = 1'b1;
            data_d  = shreg_q;
            perr_d  = perr_acc_q;
            ferr_d  = w_ferr;
            brk_d   = w_brk;
          end
        end else if (w_bit_end) begin
          stop_idx_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      hist_q     <= 1'b1;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      samp0_q    <= 1'b1;
      samp1_q    <= 1'b1;
      shreg_q    <= '0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      brk_acc_q  <= 1'b0;
      rdy_q      <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= i_rx;
      sync2_q    <= sync1_q;
      hist_q     <= sync2_q;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      samp0_q    <= samp0_d;
      samp1_q    <= samp1_d;
      shreg_q    <= shreg_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      brk_acc_q  <= brk_acc_d;
      rdy_q      <= rdy_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
    end
  end

  assign o_rdy        = rdy_q;
  assign o_data       = data_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_break      = brk_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_framed.sv
// +----------------------------------------------------------------------------+
// | tb_uart_rx_framed: 8N1 and 8E1 receivers at 10 clocks per bit              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx_framed;

  localparam int CPB = 10;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } rec_t;

  typedef struct {
    bit         sel;   // 0: no-parity receiver, 1: even-parity receiver
    logic [7:0] d;
    bit         par;
    bit         stop;
    rec_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_a, rx_b;
  logic       rdy_a, perr_a, ferr_a, brk_a, busy_a;
  logic       rdy_b, perr_b, ferr_b, brk_b, busy_b;
  logic [7:0] data_a, data_b;

  int   n_checks = 0;
  int   n_pass   = 0;
  rec_t q_a[$];
  rec_t q_b[$];

  always #5 clk = ~clk;

  uart_rx_framed #(.I_CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_a), .o_rdy(rdy_a), .o_data(data_a),
    .o_parity_err(perr_a), .o_frame_err(ferr_a), .o_break(brk_a), .o_busy(busy_a));

  uart_rx_framed #(.I_CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                   .PARITY(2), .STOP_BITS(1)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_b), .o_rdy(rdy_b), .o_data(data_b),
    .o_parity_err(perr_b), .o_frame_err(ferr_b), .o_break(brk_b), .o_busy(busy_b));

  // Every cycle with o_rdy high produces one record, so a stretched pulse shows up as an extra entry.
  always @(negedge clk) begin
    if (rdy_a) q_a.push_back(rec_t'({data_a, perr_a, ferr_a, brk_a}));
    if (rdy_b) q_b.push_back(rec_t'({data_b, perr_b, ferr_b, brk_b}));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) rx_b = v;
    else rx_a = v;
  endtask

  task automatic hold_bit(input bit sel, input logic v);
    set_line(sel, v);
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit par, input bit stop);
    q_a.delete();
    q_b.delete();
    hold_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) hold_bit(sel, d[i]);
    if (sel) hold_bit(sel, par);
    hold_bit(sel, stop);
    hold_bit(sel, 1'b1);
    hold_bit(sel, 1'b1);
  endtask

  task automatic check_frame(input string tag, input bit sel, input rec_t exp);
    rec_t r;
    int   n;
    n = sel ? q_b.size() : q_a.size();
    r = 'x;
    if (n > 0) r = sel ? q_b[0] : q_a[0];
    chk({tag, " rdy_count"}, 32'(n), 32'd1);
    chk({tag, " data"}, 32'(r.data), 32'(exp.data));
    chk({tag, " parity_err"}, 32'(r.perr), 32'(exp.perr));
    chk({tag, " frame_err"}, 32'(r.ferr), 32'(exp.ferr));
    chk({tag, " break"}, 32'(r.brk), 32'(exp.brk));
  endtask

  // Reference: even parity means the data+parity ones count must be even.
  function automatic rec_t model(input bit sel, input logic [7:0] d, input bit par, input bit stop);
    rec_t e;
    e.data = d;
    e.perr = sel && (($countones({d, par}) % 2) == 1);
    e.ferr = !stop;
    e.brk  = (d == 8'h00) && (!sel || !par) && !stop;
    return e;
  endfunction

  function automatic vec_t mkv(input bit sel, input logic [7:0] d, input bit par, input bit stop,
                               input logic [7:0] ed, input bit ep, input bit ef, input bit eb);
    vec_t v;
    v.sel = sel; v.d = d; v.par = par; v.stop = stop;
    v.exp.data = ed; v.exp.perr = ep; v.exp.ferr = ef; v.exp.brk = eb;
    return v;
  endfunction

  vec_t vecs[9];

  initial begin
    bit         busy_seen;
    bit         sel;
    logic [7:0] d;
    bit         par, stop;

    vecs[0] = mkv(1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    vecs[1] = mkv(1'b1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0);
    vecs[2] = mkv(1'b0, 8'h55, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0);
    vecs[3] = mkv(1'b0, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    vecs[4] = mkv(1'b1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
    vecs[5] = mkv(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    vecs[6] = mkv(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    vecs[7] = mkv(1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    vecs[8] = mkv(1'b1, 8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0);

    rx_a = 1'b1;
    rx_b = 1'b1;
    rst  = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset rdy", 32'({rdy_a, rdy_b}), 32'd0);
    chk("reset data", 32'({data_a, data_b}), 32'd0);
    chk("reset flags", 32'({perr_a, ferr_a, brk_a, perr_b, ferr_b, brk_b}), 32'd0);
    chk("reset busy", 32'({busy_a, busy_b}), 32'd0);
    rst = 1'b0;
    repeat (CPB) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      send_frame(vecs[i].sel, vecs[i].d, vecs[i].par, vecs[i].stop);
      check_frame($sformatf("vec%0d", i), vecs[i].sel, vecs[i].exp);
    end

    for (int i = 0; i < 20; i++) begin
      sel  = 1'($urandom_range(0, 1));
      d    = 8'($urandom);
      par  = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 3) != 0);
      send_frame(sel, d, par, stop);
      check_frame($sformatf("rand%0d", i), sel, model(sel, d, par, stop));
    end

    // Line held low for 25 bit times: one break frame, no retrigger while low.
    q_a.delete();
    rx_a = 1'b0;
    repeat (25 * CPB) @(negedge clk);
    rx_a = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check_frame("break", 1'b0, model(1'b0, 8'h00, 1'b0, 1'b0));
    repeat (10 * CPB) @(negedge clk);
    chk("break no_retrigger", 32'(q_a.size()), 32'd1);

    // Three-clock glitch is rejected by the start-bit majority vote.
    q_a.delete();
    busy_seen = 1'b0;
    rx_a = 1'b0;
    repeat (3) @(negedge clk);
    rx_a = 1'b1;
    for (int i = 0; i < CPB; i++) begin
      @(negedge clk);
      if (busy_a) busy_seen = 1'b1;
    end
    chk("glitch busy_seen", 32'(busy_seen), 32'd1);
    chk("glitch busy_low", 32'(busy_a), 32'd0);
    repeat (2 * CPB) @(negedge clk);
    chk("glitch no_rdy", 32'(q_a.size()), 32'd0);

    // Reset in the middle of data bit 4 of 0xFF abandons that frame.
    q_a.delete();
    hold_bit(1'b0, 1'b0);
    rx_a = 1'b1;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midreset busy", 32'(busy_a), 32'd0);
    chk("midreset data", 32'(data_a), 32'd0);
    rst = 1'b0;
    repeat (6 * CPB) @(negedge clk);
    chk("midreset no_rdy", 32'(q_a.size()), 32'd0);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b1);
    check_frame("after_reset", 1'b0, model(1'b0, 8'h3C, 1'b0, 1'b1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
